// File: rtl/pad_dmac_engine.sv
// Padding DMA engine: reads a WxH source matrix row by row over AXI3 and
// writes a (W+2)x(H+2) padded copy (zero / mirror / replicate borders).
module pad_dmac_engine #(
    parameter int unsigned MAX_DIM = 32,
    parameter logic [3:0]  AXI_ID  = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] src_addr_i,
    input  logic [31:0] dst_addr_i,
    input  logic [5:0]  mat_width_i,
    input  logic [5:0]  mat_height_i,
    input  logic [1:0]  pad_mode_i,
    input  logic        start_i,
    output logic        done_o,
    output logic        err_o,
    // write address channel
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    // write data channel
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    // write response channel
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    // read address channel
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    // read data channel
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o
);

    localparam int unsigned IW = $clog2(MAX_DIM);

    typedef enum logic [2:0] {
        StIdle, StRdAr, StRdR, StWrAw, StWrW, StWrB, StDone
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [6:0]  w_q, w_d;
    logic [6:0]  h_q, h_d;
    logic [1:0]  mode_q, mode_d;
    logic [6:0]  row_q, row_d;       // padded output row being produced
    logic [6:0]  col_q, col_d;       // word index within the current row transfer
    logic [4:0]  cnt_q, cnt_d;       // beats left in the current burst
    logic        err_q, err_d;
    logic        buf_valid_q, buf_valid_d;
    logic [6:0]  buf_tag_q, buf_tag_d;
    logic [31:0] buf_q [MAX_DIM];

    logic        cfg_bad;
    logic [6:0]  w2;
    logic [6:0]  src_row;
    logic [6:0]  pad_col;
    logic [6:0]  rd_rem, wr_rem;
    logic [4:0]  rd_beats, wr_beats;
    logic [31:0] rd_off, wr_off;
    logic [31:0] rd_addr, wr_addr;
    logic        border;
    logic [31:0] wr_data;
    logic [6:0]  row_nx, nx_src;
    logic        nx_read;
    logic        unused_sig;

    // Map a padded index (0..N+1) onto a source index (0..N-1) for the given mode.
    function automatic logic [6:0] map_idx(input logic [6:0] k, input logic [6:0] n,
                                           input logic [1:0] mode);
        if (k == 7'd0) begin
            return (mode == 2'd1) ? 7'd1 : 7'd0;
        end else if (k == n + 7'd1) begin
            return (mode == 2'd1) ? n - 7'd2 : n - 7'd1;
        end
        return k - 7'd1;
    endfunction

    // Datapath: addresses, burst sizes, padded write data and next-row decision.
    always_comb begin
        cfg_bad  = (mat_width_i < 6'd3) || (mat_height_i < 6'd3) ||
                   (32'(mat_width_i) > MAX_DIM) || (32'(mat_height_i) > MAX_DIM) ||
                   (pad_mode_i == 2'd3);
        w2       = w_q + 7'd2;
        src_row  = map_idx(row_q, h_q, mode_q);
        pad_col  = map_idx(col_q, w_q, mode_q);
        rd_rem   = w_q - col_q;
        wr_rem   = w2 - col_q;
        rd_beats = (rd_rem > 7'd16) ? 5'd16 : rd_rem[4:0];
        wr_beats = (wr_rem > 7'd16) ? 5'd16 : wr_rem[4:0];
        rd_off   = 32'(src_row) * 32'(w_q) + 32'(col_q);
        wr_off   = 32'(row_q) * 32'(w2) + 32'(col_q);
        rd_addr  = src_q + {rd_off[29:0], 2'b00};
        wr_addr  = dst_q + {wr_off[29:0], 2'b00};
        border   = (mode_q == 2'd0) &&
                   ((row_q == 7'd0) || (row_q == h_q + 7'd1) ||
                    (col_q == 7'd0) || (col_q == w2 - 7'd1));
        wr_data  = border ? 32'd0 : buf_q[pad_col[IW-1:0]];
        row_nx   = row_q + 7'd1;
        nx_src   = map_idx(row_nx, h_q, mode_q);
        // A zero-mode border row needs no data; otherwise reuse a buffered row.
        nx_read  = !((mode_q == 2'd0) && (row_nx == h_q + 7'd1)) &&
                   !(buf_valid_q && (buf_tag_q == nx_src));
    end

    // Next-state logic for the row-by-row read/write sequencer.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        w_d         = w_q;
        h_d         = h_q;
        mode_d      = mode_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    src_d       = src_addr_i;
                    dst_d       = dst_addr_i;
                    w_d         = {1'b0, mat_width_i};
                    h_d         = {1'b0, mat_height_i};
                    mode_d      = pad_mode_i;
                    row_d       = 7'd0;
                    col_d       = 7'd0;
                    cnt_d       = 5'd0;
                    buf_valid_d = 1'b0;
                    err_d       = cfg_bad;
                    if (cfg_bad) begin
                        state_d = StDone;
                    end else if (pad_mode_i == 2'd0) begin
                        state_d = StWrAw;
                    end else begin
                        state_d = StRdAr;
                    end
                end
            end
            StRdAr: begin
                if (arready_i) begin
                    cnt_d   = rd_beats;
                    state_d = StRdR;
                end
            end
            StRdR: begin
                if (rvalid_i) begin
                    col_d = col_q + 7'd1;
                    cnt_d = cnt_q - 5'd1;
                    if (rresp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    // Beat counting, not rlast, ends the burst.
                    if (cnt_q == 5'd1) begin
                        if (col_q + 7'd1 == w_q) begin
                            buf_valid_d = 1'b1;
                            buf_tag_d   = src_row;
                            col_d       = 7'd0;
                            state_d     = StWrAw;
                        end else begin
                            state_d = StRdAr;
                        end
                    end
                end
            end
            StWrAw: begin
                if (awready_i) begin
                    cnt_d   = wr_beats;
                    state_d = StWrW;
                end
            end
            StWrW: begin
                if (wready_i) begin
                    col_d = col_q + 7'd1;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = StWrB;
                    end
                end
            end
            StWrB: begin
                if (bvalid_i) begin
                    if (bresp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (col_q == w2) begin
                        if (row_q == h_q + 7'd1) begin
                            state_d = StDone;
                        end else begin
                            row_d   = row_nx;
                            col_d   = 7'd0;
                            state_d = nx_read ? StRdAr : StWrAw;
                        end
                    end else begin
                        state_d = StWrAw;
                    end
                end
            end
            StDone: begin
                if (!start_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and configuration registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            src_q       <= '0;
            dst_q       <= '0;
            w_q         <= '0;
            h_q         <= '0;
            mode_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            w_q         <= w_d;
            h_q         <= h_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
        end
    end

    // Row buffer capture; contents are only trusted while buf_valid_q is set.
    always_ff @(posedge clk) begin
        if (state_q == StRdR && rvalid_i) begin
            buf_q[col_q[IW-1:0]] <= rdata_i;
        end
    end

    // Outputs decode from state so an async reset clears them at once.
    always_comb begin
        done_o    = (state_q == StIdle) || (state_q == StDone);
        err_o     = err_q;
        arid_o    = AXI_ID;
        awid_o    = AXI_ID;
        wid_o     = AXI_ID;
        arsize_o  = 3'b010;
        awsize_o  = 3'b010;
        arburst_o = 2'b01;
        awburst_o = 2'b01;
        wstrb_o   = 4'hF;
        arvalid_o = (state_q == StRdAr);
        araddr_o  = arvalid_o ? rd_addr : 32'd0;
        arlen_o   = arvalid_o ? 4'(rd_beats - 5'd1) : 4'd0;
        awvalid_o = (state_q == StWrAw);
        awaddr_o  = awvalid_o ? wr_addr : 32'd0;
        awlen_o   = awvalid_o ? 4'(wr_beats - 5'd1) : 4'd0;
        wvalid_o  = (state_q == StWrW);
        wdata_o   = wvalid_o ? wr_data : 32'd0;
        wlast_o   = wvalid_o && (cnt_q == 5'd1);
        rready_o  = (state_q == StRdR);
        bready_o  = (state_q == StWrB);
    end

    assign unused_sig = ^{rid_i, bid_i, rlast_i, pad_col};

endmodule
